csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR storage and execution unit; the consumer side of the decoded CSR parameter bundle.
- Sits in writeback. Takes decoded CSR parameters, the CSR address and the source operand, then performs an atomic read-modify-write.
- Returns the old CSR value for rd through a one-entry registered response with valid/ready backpressure.
- Owns the free-running cycle and instret counters.

Parameters:
- HART_ID, 0, value returned by mhartid.
- MISA_VALUE, 32'h4000_0100, value returned by misa (RV32I).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- req_valid  input  1  CSR request present
- req_ready  output  1  request accepted when req_valid & req_ready
- read_enable  input  1  decoded read enable
- write_enable  input  1  decoded write enable
- write_func  input  2  01=RW, 10=RS, 11=RC, 00=none
- input_select  input  1  0=rs1 register value, 1=zero-extended uimm
- csr_addr  input  12  CSR address
- rs1_value  input  32  register source
- uimm  input  5  immediate source
- instr_retire  input  1  one instruction retired this cycle
- resp_valid  output  1  response held
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  old CSR value (0 if read_enable=0 or illegal)
- resp_illegal  output  1  illegal CSR access

Behaviour:
- Async reset:
  - resp_valid=0, resp_rdata=0, resp_illegal=0.
  - mscratch, mtvec, mepc and mcause = 0.
  - mcycle and minstret = 0.
- Handshake:
  - req_ready = !resp_valid | resp_ready (combinational).
  - Accept = req_valid & req_ready.
  - On accept, the response registers load at the next edge, so resp_valid rises 1 cycle after accept.
  - resp_valid clears on resp_ready without a new accept.
  - Back-to-back accepts are allowed every cycle when resp_ready=1.
  - The response holds stable while resp_valid & !resp_ready.
- Source value: src = input_select ? {27'b0, uimm} : rs1_value.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - write_func=00: no write and no read; resp_illegal=1.
- Implemented CSRs:
  - mscratch 0x340: RW, all 32 bits.
  - mtvec 0x305: RW, bits[1:0] read 0 (direct mode only).
  - mepc 0x341: RW, bits[1:0] read 0.
  - mcause 0x342: RW, all bits.
  - mcycle 0xB00 / mcycleh 0xB80: RW, low/high halves of 64-bit mcycle.
  - minstret 0xB02 / minstreth 0xB82: RW, low/high halves of 64-bit minstret.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows of the counters.
  - misa 0x301: read-only in practice; writes are accepted and ignored (WARL).
  - mhartid 0xF14: read-only.
- Illegal access:
  - Any address not listed above.
  - write_enable=1 to an address with addr[11:10]==2'b11.
  - Result: no state change, resp_rdata=0, resp_illegal=1.
- Read value: the value before this request's write, captured at the accept edge.
- Write commit: at the accept edge, and only when write_enable=1 and the access is legal.
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments when instr_retire=1.
  - Both wrap 2^64-1 -> 0 with carry from the low to the high half.
  - Simultaneous CSR write to either half and increment: the written half takes the CSR value, the other half holds, and the increment is dropped that cycle.
  - instr_retire on the same cycle as a CSR accept is counted normally unless that accept writes minstret/minstreth.
- Requests with req_valid=1 and !req_ready have no side effects.
- Reset asserted mid-response discards the response; resp_valid=0 immediately.

Test Plan:
- RW then read:
  - Step 1: write_func=01, src=0xDEAD_BEEF to mscratch, rd=x5 -> resp_rdata=0, resp_illegal=0.
  - Step 2: RS with src=0 -> resp_rdata=0xDEAD_BEEF.
- RS/RC, uimm path, mscratch=0xF0F0_0000:
  - RS uimm=5'h0F -> next read returns 0xF0F0_000F.
  - RC uimm=5'h03 -> next read returns 0xF0F0_000C.
- Counter carry and priority:
  - Write mcycle=0xFFFF_FFFE, mcycleh=0 -> two cycles later cycleh reads 1.
  - Write minstret with instr_retire=1 in the same cycle -> next read equals the written value, not +1.
- Illegal accesses:
  - Write to cycle 0xC00 -> resp_illegal=1, counter unaffected.
  - Read of 0x7C0 -> resp_illegal=1, resp_rdata=0.
  - write_func=00 -> resp_illegal=1.
- Backpressure: hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable, second request not applied until resp_ready=1.
- Async reset asserted mid-test -> all outputs 0 within the same cycle; mscratch reads 0 and mhartid reads HART_ID afterward.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage with an atomic read-modify-write per
// request, a one-entry registered response (valid/ready) and the free-running
// 64-bit mcycle / minstret counters.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [1:0]  write_func,
  input  logic        input_select,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_value,
  input  logic [4:0]  uimm,
  input  logic        instr_retire,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal
);

  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] FUNC_RW = 2'b01;
  localparam logic [1:0] FUNC_RS = 2'b10;
  localparam logic [1:0] FUNC_RC = 2'b11;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_illegal_q, resp_illegal_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        accept;
  logic        addr_known;
  logic        illegal;
  logic        do_write;
  logic [31:0] old_value;
  logic [31:0] src_value;
  logic [31:0] new_value;

  assign req_ready    = !resp_valid_q || resp_ready;
  assign accept       = req_valid && req_ready;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;

  // Decode the address and fetch the pre-write value of the selected CSR.
  always_comb begin
    addr_known = 1'b1;
    old_value  = 32'h0000_0000;
    case (csr_addr)
      ADDR_MSCRATCH:                 old_value = mscratch_q;
      ADDR_MTVEC:                    old_value = mtvec_q;
      ADDR_MEPC:                     old_value = mepc_q;
      ADDR_MCAUSE:                   old_value = mcause_q;
      ADDR_MCYCLE, ADDR_CYCLE:       old_value = mcycle_q[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:     old_value = mcycle_q[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   old_value = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_value = minstret_q[63:32];
      ADDR_MISA:                     old_value = MISA_VALUE;
      ADDR_MHARTID:                  old_value = HART_ID;
      default:                       addr_known = 1'b0;
    endcase
  end

  // Legality check and read-modify-write result for the current request.
  always_comb begin
    src_value = input_select ? {27'd0, uimm} : rs1_value;
    illegal   = (write_func == 2'b00) || !addr_known ||
                (write_enable && (csr_addr[11:10] == 2'b11));
    case (write_func)
      FUNC_RW: new_value = src_value;
      FUNC_RS: new_value = old_value | src_value;
      FUNC_RC: new_value = old_value & ~src_value;
      default: new_value = old_value;
    endcase
    do_write = accept && write_enable && !illegal;
  end

  // Next state of the plain storage CSRs; mtvec/mepc keep bits[1:0] at zero.
  always_comb begin
    mscratch_d = mscratch_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (do_write) begin
      case (csr_addr)
        ADDR_MSCRATCH: mscratch_d = new_value;
        ADDR_MTVEC:    mtvec_d    = {new_value[31:2], 2'b00};
        ADDR_MEPC:     mepc_d     = {new_value[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = new_value;
        default:       mscratch_d = mscratch_q;
      endcase
    end else begin
      mscratch_d = mscratch_q;
    end
  end

  // Counters: a CSR write to either half wins and suppresses that cycle's increment.
  always_comb begin
    if (do_write && (csr_addr == ADDR_MCYCLE)) begin
      mcycle_d = {mcycle_q[63:32], new_value};
    end else if (do_write && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle_d = {new_value, mcycle_q[31:0]};
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end
    if (do_write && (csr_addr == ADDR_MINSTRET)) begin
      minstret_d = {minstret_q[63:32], new_value};
    end else if (do_write && (csr_addr == ADDR_MINSTRETH)) begin
      minstret_d = {new_value, minstret_q[31:0]};
    end else if (instr_retire) begin
      minstret_d = minstret_q + 64'd1;
    end else begin
      minstret_d = minstret_q;
    end
  end

  // Response slot: load on accept, drop when consumed, otherwise hold.
  always_comb begin
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    if (accept) begin
      resp_valid_d   = 1'b1;
      resp_rdata_d   = (read_enable && !illegal) ? old_value : 32'h0000_0000;
      resp_illegal_d = illegal;
    end else if (resp_ready) begin
      resp_valid_d   = 1'b0;
    end else begin
      resp_valid_d   = resp_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0000_0000;
      resp_illegal_q <= 1'b0;
      mscratch_q     <= 32'h0000_0000;
      mtvec_q        <= 32'h0000_0000;
      mepc_q         <= 32'h0000_0000;
      mcause_q       <= 32'h0000_0000;
      mcycle_q       <= 64'd0;
      minstret_q     <= 64'd0;
    end else begin
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      mscratch_q     <= mscratch_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scenarios plus randomized traffic for csr_file,
// checked cycle by cycle against a behavioural CSR model.
module tb_csr_file;

  localparam logic [31:0] HART = 32'h0000_0000;
  localparam logic [31:0] MISA = 32'h4000_0100;
  localparam logic [1:0]  F_NONE = 2'b00;
  localparam logic [1:0]  F_RW   = 2'b01;
  localparam logic [1:0]  F_RS   = 2'b10;
  localparam logic [1:0]  F_RC   = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, read_enable, write_enable;
  logic [1:0]  write_func;
  logic        input_select;
  logic [11:0] csr_addr;
  logic [31:0] rs1_value;
  logic [4:0]  uimm;
  logic        instr_retire;
  logic        resp_valid, resp_ready, resp_illegal;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  logic [31:0] m_scratch, m_tvec, m_epc, m_cause;
  logic [63:0] m_cycle, m_instret;
  logic        m_rv, m_ill;
  logic [31:0] m_rdata;

  csr_file #(.HART_ID(HART), .MISA_VALUE(MISA)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .read_enable(read_enable), .write_enable(write_enable),
    .write_func(write_func), .input_select(input_select),
    .csr_addr(csr_addr), .rs1_value(rs1_value), .uimm(uimm),
    .instr_retire(instr_retire),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_illegal(resp_illegal)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit known(input logic [11:0] a);
    case (a)
      12'h340, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h301, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Architecturally visible value of a CSR in the model
  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h340:          return m_scratch;
      12'h305:          return m_tvec & 32'hFFFF_FFFC;
      12'h341:          return m_epc & 32'hFFFF_FFFC;
      12'h342:          return m_cause;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'h301:          return MISA;
      12'hF14:          return HART;
      default:          return 32'h0000_0000;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = 32'h0; m_tvec = 32'h0; m_epc = 32'h0; m_cause = 32'h0;
    m_cycle = 64'd0; m_instret = 64'd0;
    m_rv = 1'b0; m_ill = 1'b0; m_rdata = 32'h0;
  endtask

  // One clock edge of the model, using the inputs currently driven
  task automatic model_edge();
    bit acc, ill;
    logic [31:0] old, src, nv;
    logic [63:0] cyc_n, ins_n;
    acc   = req_valid && (!m_rv || resp_ready);
    ill   = (write_func == F_NONE) || !known(csr_addr) ||
            (write_enable && (csr_addr[11:10] == 2'b11));
    old   = m_csr(csr_addr);
    src   = input_select ? {27'd0, uimm} : rs1_value;
    nv    = (write_func == F_RW) ? src : ((write_func == F_RS) ? (old | src) : (old & ~src));
    cyc_n = m_cycle + 64'd1;
    ins_n = m_instret + {63'd0, instr_retire};
    if (acc) begin
      m_rv    = 1'b1;
      m_ill   = ill;
      m_rdata = (read_enable && !ill) ? old : 32'h0;
      if (write_enable && !ill) begin
        case (csr_addr)
          12'h340: m_scratch = nv;
          12'h305: m_tvec    = nv;
          12'h341: m_epc     = nv;
          12'h342: m_cause   = nv;
          12'hB00: cyc_n     = {m_cycle[63:32], nv};
          12'hB80: cyc_n     = {nv, m_cycle[31:0]};
          12'hB02: ins_n     = {m_instret[63:32], nv};
          12'hB82: ins_n     = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
    end else if (resp_ready) begin
      m_rv = 1'b0;
    end
    m_cycle   = cyc_n;
    m_instret = ins_n;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(!m_rv || resp_ready));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("resp_valid", 32'(resp_valid), 32'(m_rv));
    if (m_rv) begin
      check_eq("resp_rdata", resp_rdata, m_rdata);
      check_eq("resp_illegal", 32'(resp_illegal), 32'(m_ill));
    end
  endtask

  task automatic drive(input bit v, input bit re, input bit we, input logic [1:0] wf,
                       input bit sel, input logic [11:0] a, input logic [31:0] r,
                       input logic [4:0] u, input bit ret, input bit rr);
    req_valid = v; read_enable = re; write_enable = we; write_func = wf;
    input_select = sel; csr_addr = a; rs1_value = r; uimm = u;
    instr_retire = ret; resp_ready = rr;
    step();
  endtask

  task automatic csr_op(input logic [1:0] wf, input logic [11:0] a, input logic [31:0] src);
    drive(1'b1, 1'b1, wf != F_NONE, wf, 1'b0, a, src, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic csr_opi(input logic [1:0] wf, input logic [11:0] a, input logic [4:0] u);
    drive(1'b1, 1'b1, 1'b1, wf, 1'b1, a, 32'h0, u, 1'b0, 1'b1);
  endtask

  task automatic csr_rd(input logic [11:0] a);
    drive(1'b1, 1'b1, 1'b0, F_RS, 1'b0, a, 32'h0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, F_NONE, 1'b0, 12'h000, 32'h0, 5'd0, 1'b0, 1'b1);
  endtask

  logic [11:0] pool [18] = '{12'h340, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                             12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                             12'h301, 12'hF14, 12'h7C0, 12'h000, 12'h343, 12'hFFF};

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; read_enable = 1'b0; write_enable = 1'b0; write_func = F_NONE;
    input_select = 1'b0; csr_addr = 12'h000; rs1_value = 32'h0; uimm = 5'd0;
    instr_retire = 1'b0; resp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_illegal", 32'(resp_illegal), 32'd0);
    reset = 1'b0;

    // RW then read back
    csr_op(F_RW, 12'h340, 32'hDEAD_BEEF);
    check_eq("rw_old", resp_rdata, 32'h0);
    check_eq("rw_legal", 32'(resp_illegal), 32'd0);
    csr_op(F_RS, 12'h340, 32'h0);
    check_eq("rw_readback", resp_rdata, 32'hDEAD_BEEF);

    // RS / RC through the uimm path
    csr_op(F_RW, 12'h340, 32'hF0F0_0000);
    csr_opi(F_RS, 12'h340, 5'h0F);
    check_eq("rs_old", resp_rdata, 32'hF0F0_0000);
    csr_opi(F_RC, 12'h340, 5'h03);
    check_eq("rc_old", resp_rdata, 32'hF0F0_000F);
    csr_rd(12'h340);
    check_eq("rc_result", resp_rdata, 32'hF0F0_000C);

    // mtvec low bits read as zero
    csr_op(F_RW, 12'h305, 32'h1234_5677);
    csr_rd(12'h305);
    check_eq("mtvec_mask", resp_rdata, 32'h1234_5674);

    // Counter carry from low to high half
    csr_op(F_RW, 12'hB00, 32'hFFFF_FFFE);
    csr_op(F_RW, 12'hB80, 32'h0);
    idle();
    idle();
    csr_rd(12'hC80);
    check_eq("cycle_carry", resp_rdata, 32'd1);

    // Write to minstret beats a same-cycle retire
    drive(1'b1, 1'b1, 1'b1, F_RW, 1'b0, 12'hB02, 32'h0000_1234, 5'd0, 1'b1, 1'b1);
    csr_rd(12'hC02);
    check_eq("instret_prio", resp_rdata, 32'h0000_1234);

    // Illegal accesses
    csr_op(F_RW, 12'hC00, 32'h0);
    check_eq("ill_ro_write", 32'(resp_illegal), 32'd1);
    csr_rd(12'h7C0);
    check_eq("ill_addr", 32'(resp_illegal), 32'd1);
    check_eq("ill_addr_rdata", resp_rdata, 32'h0);
    drive(1'b1, 1'b1, 1'b0, F_NONE, 1'b0, 12'h340, 32'h0, 5'd0, 1'b0, 1'b1);
    check_eq("ill_nofunc", 32'(resp_illegal), 32'd1);
    check_eq("ill_nofunc_rdata", resp_rdata, 32'h0);

    // Backpressure: response must hold and the second request must wait
    csr_op(F_RW, 12'h340, 32'h0000_1111);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'h0000_2222, 5'd0, 1'b0, 1'b0);
      check_eq("bp_ready_low", 32'(req_ready), 32'd0);
      check_eq("bp_hold", resp_rdata, 32'hF0F0_000C);
    end
    drive(1'b1, 1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'h0000_2222, 5'd0, 1'b0, 1'b1);
    check_eq("bp_second_old", resp_rdata, 32'h0000_1111);
    csr_rd(12'h340);
    check_eq("bp_second_applied", resp_rdata, 32'h0000_2222);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] wf;
      wf = ($urandom_range(0, 9) == 0) ? F_NONE : 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) != 0, 1'($urandom), (wf != F_NONE) && ($urandom_range(0, 2) != 0),
            wf, 1'($urandom), pool[$urandom_range(0, 17)], $urandom, 5'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);
    end
    idle();

    // Asynchronous reset in the middle of a held response
    csr_op(F_RW, 12'h340, 32'hA5A5_A5A5);
    csr_rd(12'h340);
    check_eq("pre_reset_rdata", resp_rdata, 32'hA5A5_A5A5);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("arst_valid", 32'(resp_valid), 32'd0);
    check_eq("arst_rdata", resp_rdata, 32'h0);
    check_eq("arst_illegal", 32'(resp_illegal), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    csr_rd(12'h340);
    check_eq("post_reset_mscratch", resp_rdata, 32'h0);
    csr_rd(12'hF14);
    check_eq("post_reset_mhartid", resp_rdata, HART);
    csr_rd(12'h301);
    check_eq("misa", resp_rdata, MISA);
    csr_rd(12'hC00);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
